// File: rtl/multicycle_control_if.sv
// Control-unit bus: instruction/flag inputs from the datapath and the
// per-cycle control word driven back to it.
interface multicycle_control_if;
  logic [31:0] Instr;
  logic        ALUFlags;
  logic [2:0]  ALUControl;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic        AdrSrc;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        Zflag;
  logic [3:0]  state;

  // datapath side
  modport master (
    output Instr, ALUFlags,
    input  ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
    input  PCWrite, IRWrite, RegWrite, MemWrite, ImmSrc, RegSrc, Zflag, state
  );

  // control-unit side
  modport slave (
    input  Instr, ALUFlags,
    output ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
    output PCWrite, IRWrite, RegWrite, MemWrite, ImmSrc, RegSrc, Zflag, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle ARM-subset control FSM: fetch/decode, LDR/STR, ADD/SUB/MOV/CMP
// (register or immediate), conditional branch, with a Z flag register and
// MEM_WAIT extra cycles on every memory-access state.
module multicycle_control #(
  parameter int MEM_WAIT = 0
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.slave  bus
);
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  logic [3:0] state_q, state_n;
  logic [2:0] wait_cnt;
  logic       zflag_q, cond_ex_q;
  logic [2:0] alu_ctl_q;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       imm, sbit;
  logic       cond_ex, dp_ok, mem_state, mem_done;
  logic [2:0] dec_ctl;

  logic [2:0] alu_ctl;
  logic       src_a, adr_src, pc_w, ir_w, reg_w, mem_w;
  logic [1:0] src_b, res_src;
  logic       unused_instr;

  assign cond = bus.Instr[31:28];
  assign op   = bus.Instr[27:26];
  assign imm  = bus.Instr[25];
  assign cmd  = bus.Instr[24:21];
  assign sbit = bus.Instr[20];
  assign unused_instr = ^bus.Instr[19:0];

  assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign mem_done  = (wait_cnt == 3'(MEM_WAIT));

  // Condition evaluation and data-processing opcode decode
  always_comb begin
    cond_ex = 1'b0;
    dp_ok   = 1'b1;
    dec_ctl = 3'b000;
    case (cond)
      4'b0000: cond_ex = zflag_q;
      4'b0001: cond_ex = ~zflag_q;
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
    case (cmd)
      4'b0100: dec_ctl = {sbit, 2'b00};
      4'b0010: dec_ctl = {sbit, 2'b01};
      4'b1101: dec_ctl = {sbit, 2'b10};
      4'b1010: dec_ctl = 3'b011;
      default: dp_ok   = 1'b0;
    endcase
  end

  // Next-state logic; memory states hold until the wait counter expires
  always_comb begin
    state_n = state_q;
    case (state_q)
      FETCH:  if (mem_done) state_n = DECODE;
      DECODE: begin
        case (op)
          2'b01:   state_n = MEMADR;
          2'b10:   state_n = BRANCH;
          2'b00:   state_n = !dp_ok ? FETCH : (imm ? EXECI : EXECR);
          default: state_n = FETCH;
        endcase
      end
      MEMADR: state_n = bus.Instr[20] ? MEMRD : MEMWR;
      MEMRD:  if (mem_done) state_n = MEMWB;
      MEMWB:  state_n = FETCH;
      MEMWR:  if (mem_done) state_n = FETCH;
      EXECR:  state_n = ALUWB;
      EXECI:  state_n = ALUWB;
      ALUWB:  state_n = FETCH;
      BRANCH: state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  // State register and wait counter (counter restarts on every state entry)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      wait_cnt <= 3'd0;
    end else begin
      state_q  <= state_n;
      wait_cnt <= (mem_state && state_n == state_q) ? wait_cnt + 3'd1 : 3'd0;
    end
  end

  // Decode-time latches and the architectural Z flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_ex_q <= 1'b0;
      alu_ctl_q <= 3'b000;
      zflag_q   <= 1'b0;
    end else begin
      if (state_q == DECODE) begin
        cond_ex_q <= cond_ex;
        alu_ctl_q <= (op == 2'b00 && dp_ok) ? dec_ctl : 3'b000;
      end
      if ((state_q == EXECR || state_q == EXECI) && cond_ex_q &&
          (alu_ctl_q == 3'b100 || alu_ctl_q == 3'b101 ||
           alu_ctl_q == 3'b110 || alu_ctl_q == 3'b011))
        zflag_q <= bus.ALUFlags;
    end
  end

  // Per-state control word; anything not set here stays 0
  always_comb begin
    alu_ctl = 3'b000;
    src_a   = 1'b0;
    src_b   = 2'b00;
    res_src = 2'b00;
    adr_src = 1'b0;
    pc_w    = 1'b0;
    ir_w    = 1'b0;
    reg_w   = 1'b0;
    mem_w   = 1'b0;
    case (state_q)
      FETCH: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        res_src = 2'b10;
        ir_w    = mem_done;
        pc_w    = mem_done;
      end
      DECODE: begin
        src_a = 1'b1;
        src_b = 2'b10;
      end
      MEMADR: src_b = 2'b01;
      MEMRD:  adr_src = 1'b1;
      MEMWB: begin
        res_src = 2'b01;
        reg_w   = cond_ex_q;
      end
      MEMWR: begin
        adr_src = 1'b1;
        mem_w   = cond_ex_q & mem_done;
      end
      EXECR: alu_ctl = alu_ctl_q;
      EXECI: begin
        src_b   = 2'b01;
        alu_ctl = alu_ctl_q;
      end
      ALUWB: reg_w = cond_ex_q && (alu_ctl_q != 3'b011);
      BRANCH: begin
        src_b   = 2'b01;
        res_src = 2'b10;
        pc_w    = cond_ex_q;
      end
      default: ;
    endcase
  end

  assign bus.ALUControl = alu_ctl;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ResultSrc  = res_src;
  assign bus.AdrSrc     = adr_src;
  // strobes are forced low for as long as reset is held
  assign bus.PCWrite    = pc_w  & ~reset;
  assign bus.IRWrite    = ir_w  & ~reset;
  assign bus.RegWrite   = reg_w & ~reset;
  assign bus.MemWrite   = mem_w & ~reset;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
  assign bus.Zflag      = zflag_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: one instance with MEM_WAIT 0, one with 2.
// Expected strobe cycles are queued per instruction; monitors pop and
// compare whenever a DUT raises any write strobe.
module tb_multicycle_control;
  typedef struct packed {
    logic [3:0] st;
    logic [3:0] wr;   // {PCWrite, IRWrite, RegWrite, MemWrite}
    logic [1:0] res;
    logic       adr;
  } ev_t;

  localparam ev_t EV_FETCH  = '{st: 4'd0, wr: 4'b1100, res: 2'b10, adr: 1'b0};
  localparam ev_t EV_ALUWB  = '{st: 4'd8, wr: 4'b0010, res: 2'b00, adr: 1'b0};
  localparam ev_t EV_BRANCH = '{st: 4'd9, wr: 4'b1000, res: 2'b10, adr: 1'b0};
  localparam ev_t EV_MEMWR  = '{st: 4'd5, wr: 4'b0001, res: 2'b00, adr: 1'b1};
  localparam ev_t EV_MEMWB  = '{st: 4'd4, wr: 4'b0010, res: 2'b01, adr: 1'b0};

  logic clk = 1'b0;
  logic rst0, rst2;
  int   tests = 0;
  int   fails = 0;
  ev_t  q0[$];
  ev_t  q2[$];
  ev_t  got0, exp0, got2, exp2;

  always #5 clk = ~clk;

  multicycle_control_if a0();
  multicycle_control_if a2();

  multicycle_control #(.MEM_WAIT(0)) dut0 (.clk(clk), .reset(rst0), .bus(a0));
  multicycle_control #(.MEM_WAIT(2)) dut2 (.clk(clk), .reset(rst2), .bus(a2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input ev_t e);
    if (d == 0) q0.push_back(e);
    else        q2.push_back(e);
  endtask

  function automatic logic [3:0] st_of(input int d);
    return (d == 0) ? a0.state : a2.state;
  endfunction

  // Execute one instruction starting in the current FETCH cycle, recording
  // the state trace until the next FETCH; optionally pulse reset on DUT2
  // once abort_at states have been recorded.
  task automatic run(input int d, input string name, input logic [31:0] ins,
                     input logic flg, input logic [63:0] exp_seq, input int n,
                     input int abort_at);
    logic [63:0] act = '0;
    int          cnt = 0;
    logic [3:0]  st;
    logic [3:0]  last = 4'd0;
    bit          done = 1'b0;
    if (d == 0) begin a0.Instr = ins; a0.ALUFlags = flg; end
    else        begin a2.Instr = ins; a2.ALUFlags = flg; end
    while (!done) begin
      st = st_of(d);
      if (cnt > 0 && st == 4'd0 && last != 4'd0) begin
        done = 1'b1;
      end else begin
        act  = {act[59:0], st};
        last = st;
        cnt++;
        if (cnt == abort_at) begin
          rst2 = 1'b1;
          #1;
          check({name, " abort state"}, 64'(a2.state), 64'd0);
          @(negedge clk); #1;
          check({name, " abort strobes"},
                64'({a2.PCWrite, a2.IRWrite, a2.RegWrite, a2.MemWrite}), 64'd0);
          rst2 = 1'b0;
          done = 1'b1;
        end else if (cnt >= 40) begin
          tests++;
          fails++;
          $display("FAIL %s timeout: no return to FETCH after %0d cycles", name, cnt);
          done = 1'b1;
        end else begin
          @(negedge clk); #1;
        end
      end
    end
    check({name, " seq"}, act, exp_seq);
    check({name, " len"}, 64'(cnt), 64'(n));
  endtask

  // Strobe monitors: sample mid-low-phase, after the stimulus has queued
  always @(negedge clk) begin
    #3;
    if (!rst0 && (a0.PCWrite | a0.IRWrite | a0.RegWrite | a0.MemWrite)) begin
      got0 = '{st: a0.state, wr: {a0.PCWrite, a0.IRWrite, a0.RegWrite, a0.MemWrite},
               res: a0.ResultSrc, adr: a0.AdrSrc};
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL dut0 strobe: got %h, expected none", got0);
      end else begin
        exp0 = q0.pop_front();
        if (got0 !== exp0) begin
          fails++;
          $display("FAIL dut0 strobe: got %h, expected %h", got0, exp0);
        end
      end
    end
  end

  always @(negedge clk) begin
    #3;
    if (!rst2 && (a2.PCWrite | a2.IRWrite | a2.RegWrite | a2.MemWrite)) begin
      got2 = '{st: a2.state, wr: {a2.PCWrite, a2.IRWrite, a2.RegWrite, a2.MemWrite},
               res: a2.ResultSrc, adr: a2.AdrSrc};
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL dut2 strobe: got %h, expected none", got2);
      end else begin
        exp2 = q2.pop_front();
        if (got2 !== exp2) begin
          fails++;
          $display("FAIL dut2 strobe: got %h, expected %h", got2, exp2);
        end
      end
    end
  end

  initial begin
    rst0 = 1'b1;
    rst2 = 1'b1;
    a0.Instr = 32'hEC000000;  a0.ALUFlags = 1'b0;
    a2.Instr = 32'hEC000000;  a2.ALUFlags = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset state0", 64'(a0.state), 64'd0);
    check("reset zflag0", 64'(a0.Zflag), 64'd0);
    check("reset strobes0", 64'({a0.PCWrite, a0.IRWrite, a0.RegWrite, a0.MemWrite}), 64'd0);
    check("reset strobes2", 64'({a2.PCWrite, a2.IRWrite, a2.RegWrite, a2.MemWrite}), 64'd0);

    // ---- MEM_WAIT 0 ----
    rst0 = 1'b0;
    push(0, EV_FETCH);
    run(0, "beq z0", 32'h0A000002, 1'b0, 64'h019, 3, -1);
    push(0, EV_FETCH); push(0, EV_ALUWB);
    run(0, "add", 32'hE0810002, 1'b1, 64'h0168, 4, -1);
    check("add zflag", 64'(a0.Zflag), 64'd0);
    push(0, EV_FETCH);
    run(0, "cmp", 32'hE1500001, 1'b1, 64'h0168, 4, -1);
    check("cmp zflag", 64'(a0.Zflag), 64'd1);
    push(0, EV_FETCH); push(0, EV_BRANCH);
    run(0, "beq z1", 32'h0A000002, 1'b0, 64'h019, 3, -1);
    push(0, EV_FETCH);
    run(0, "addsne", 32'h10910002, 1'b0, 64'h0168, 4, -1);
    check("addsne zflag", 64'(a0.Zflag), 64'd1);
    push(0, EV_FETCH); push(0, EV_ALUWB);
    run(0, "adds", 32'hE0910002, 1'b0, 64'h0168, 4, -1);
    check("adds zflag", 64'(a0.Zflag), 64'd0);
    push(0, EV_FETCH);
    run(0, "and nop", 32'hE0010002, 1'b1, 64'h01, 2, -1);
    push(0, EV_FETCH); push(0, EV_MEMWR);
    run(0, "str", 32'hE5812004, 1'b0, 64'h0125, 4, -1);
    push(0, EV_FETCH); push(0, EV_ALUWB);
    run(0, "addi", 32'hE2810004, 1'b0, 64'h0178, 4, -1);
    rst0 = 1'b1;

    // ---- MEM_WAIT 2 ----
    @(negedge clk); #1;
    rst2 = 1'b0;
    push(2, EV_FETCH); push(2, EV_MEMWB);
    run(2, "ldr w2", 32'hE5912004, 1'b0, 64'h000123334, 9, -1);
    push(2, EV_FETCH);
    run(2, "str abort", 32'hE5812004, 1'b0, 64'h0001255, 7, 7);
    push(2, EV_FETCH);
    run(2, "nop after rst", 32'hEC000000, 1'b0, 64'h0001, 4, -1);
    rst2 = 1'b1;

    repeat (3) @(negedge clk);
    #5;
    check("q0 drained", 64'(q0.size()), 64'd0);
    check("q2 drained", 64'(q2.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
